// File: rtl/imem_stream_loader_if.sv
// ==========================================================================
// imem_stream_loader_if : stream-in / Avalon-MM-out bundle of the loader
// Revision: 1.0
// ==========================================================================
`default_nettype none

interface imem_stream_loader_if;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        s_axis_tlast;
   logic [31:0] avm_address;
   logic [31:0] avm_writedata;
   logic        avm_write;
   logic        avm_waitrequest;

   // master: image source plus imem/mux side; slave: the loader itself
   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
      input  s_axis_tready,
      input  avm_address, avm_writedata, avm_write,
      output avm_waitrequest
   );

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
      output s_axis_tready,
      output avm_address, avm_writedata, avm_write,
      input  avm_waitrequest
   );
endinterface

`default_nettype wire

// File: rtl/imem_stream_loader.sv
// ==========================================================================
// imem_stream_loader : copies an AXI-Stream program image into imem over Avalon-MM
// Revision: 1.0
// ==========================================================================
`default_nettype none

module imem_stream_loader #(
   parameter int IMEM_NUM_BYTES = 131072,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = $clog2(IMEM_NUM_BYTES / 4) + 1
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             start,
   input  wire logic [31:0]      base_addr,
   imem_stream_loader_if.slave   bus,
   output logic                  imem_select,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [CNT_W-1:0]      words_written
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCEPT = 3'd1,
      S_WRITE  = 3'd2,
      S_FINISH = 3'd3,
      S_ABORT  = 3'd4
   } state_t;

   localparam logic [32:0] c_imem_limit = 33'(IMEM_NUM_BYTES);
   localparam logic [31:0] c_timeout    = 32'(TIMEOUT_CYCLES);

   state_t           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      data_q, data_d;
   logic             tlast_q, tlast_d;
   logic             tready_q, tready_d;
   logic             write_q, write_d;
   logic             select_q, select_d;
   logic             hold_q, hold_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic [CNT_W-1:0] words_q, words_d;
   logic [31:0]      idle_cnt_q, idle_cnt_d;

   // Status outputs are registered with the state they describe, so they
   // change on the same edge the FSM enters FINISH or ABORT.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      data_d     = data_q;
      tlast_d    = tlast_q;
      tready_d   = tready_q;
      write_d    = write_q;
      select_d   = select_q;
      hold_d     = hold_q;
      busy_d     = busy_q;
      done_d     = done_q;
      error_d    = error_q;
      words_d    = words_q;
      idle_cnt_d = idle_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               done_d     = 1'b0;
               error_d    = 1'b0;
               words_d    = '0;
               idle_cnt_d = '0;
               addr_d     = base_addr & ~32'h3;
               hold_d     = 1'b1;
               if ({1'b0, addr_d} >= c_imem_limit) begin
                  state_d = S_ABORT;
                  error_d = 1'b1;
               end else begin
                  state_d  = S_ACCEPT;
                  busy_d   = 1'b1;
                  select_d = 1'b1;
                  tready_d = 1'b1;
               end
            end
         end
         S_ACCEPT: begin
            if (bus.s_axis_tvalid) begin
               data_d     = bus.s_axis_tdata;
               tlast_d    = bus.s_axis_tlast;
               write_d    = 1'b1;
               tready_d   = 1'b0;
               idle_cnt_d = '0;
               state_d    = S_WRITE;
            end else if (TIMEOUT_CYCLES != 0) begin
               idle_cnt_d = idle_cnt_q + 32'd1;
               if (idle_cnt_d >= c_timeout) begin
                  state_d  = S_ABORT;
                  tready_d = 1'b0;
                  busy_d   = 1'b0;
                  select_d = 1'b0;
                  error_d  = 1'b1;
               end
            end
         end
         S_WRITE: begin
            if (!bus.avm_waitrequest) begin
               write_d = 1'b0;
               addr_d  = addr_q + 32'd4;
               if (words_q != {CNT_W{1'b1}}) begin
                  words_d = words_q + 1'b1;
               end
               if (tlast_q) begin
                  state_d  = S_FINISH;
                  busy_d   = 1'b0;
                  select_d = 1'b0;
                  hold_d   = 1'b0;
                  done_d   = 1'b1;
               end else if ({1'b0, addr_q} + 33'd4 >= c_imem_limit) begin
                  state_d  = S_ABORT;
                  busy_d   = 1'b0;
                  select_d = 1'b0;
                  error_d  = 1'b1;
               end else begin
                  state_d  = S_ACCEPT;
                  tready_d = 1'b1;
               end
            end
         end
         S_FINISH, S_ABORT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         tlast_q    <= 1'b0;
         tready_q   <= 1'b0;
         write_q    <= 1'b0;
         select_q   <= 1'b0;
         hold_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         words_q    <= '0;
         idle_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         tlast_q    <= tlast_d;
         tready_q   <= tready_d;
         write_q    <= write_d;
         select_q   <= select_d;
         hold_q     <= hold_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         words_q    <= words_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   // addr_q only advances once a write is accepted, so it doubles as avm_address
   assign bus.s_axis_tready = tready_q;
   assign bus.avm_address   = addr_q;
   assign bus.avm_writedata = data_q;
   assign bus.avm_write     = write_q;
   assign imem_select       = select_q;
   assign cpu_hold          = hold_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign error             = error_q;
   assign words_written     = words_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_stream_loader.sv
// ==========================================================================
// tb_imem_stream_loader : scoreboard bench for imem_stream_loader
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_imem_stream_loader;
   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] base_addr;
   logic        imem_select, cpu_hold, busy, done, error;
   logic [15:0] words_written;

   imem_stream_loader_if bus();

   imem_stream_loader #(.TIMEOUT_CYCLES(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .base_addr     (base_addr),
      .bus           (bus),
      .imem_select   (imem_select),
      .cpu_hold      (cpu_hold),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .words_written (words_written)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
   wr_t exp_q[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int acc_edge = 0;
   int stall_n = 0;
   int stall_cnt = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] held_a, held_d;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   always @(posedge clk) cyc++;

   // Avalon slave model: stalls every new write for stall_n cycles
   initial bus.avm_waitrequest = 1'b0;
   always @(posedge clk) begin
      #1;
      if (bus.avm_write && stall_cnt < stall_n) begin
         bus.avm_waitrequest = 1'b1;
         stall_cnt++;
      end else begin
         bus.avm_waitrequest = 1'b0;
         if (!bus.avm_write) stall_cnt = 0;
      end
   end

   // Monitor: pops the scoreboard on every accepted write
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.avm_write) begin
            check("tready_low_while_writing", 64'(bus.s_axis_tready), 64'd0);
            check("select_during_write", 64'(imem_select), 64'd1);
            if (prev_stall) begin
               check("addr_stable", 64'(bus.avm_address), 64'(held_a));
               check("data_stable", 64'(bus.avm_writedata), 64'(held_d));
            end
            if (bus.avm_waitrequest) begin
               prev_stall = 1'b1;
               held_a = bus.avm_address;
               held_d = bus.avm_writedata;
            end else begin
               prev_stall = 1'b0;
               acc_edge = cyc + 1;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                           bus.avm_address, bus.avm_writedata);
               end else begin
                  wr_t e;
                  e = exp_q.pop_front();
                  check("write_addr", 64'(bus.avm_address), 64'(e.a));
                  check("write_data", 64'(bus.avm_writedata), 64'(e.d));
               end
            end
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] b);
      base_addr = b;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input logic last);
      bus.s_axis_tdata  = d;
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tlast  = last;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (bus.s_axis_tready) begin
            tick();
            bus.s_axis_tvalid = 1'b0;
            bus.s_axis_tlast  = 1'b0;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL send_timeout: word %0h never accepted", d);
      bus.s_axis_tvalid = 1'b0;
   endtask

   task automatic wait_end(input string name);
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (done || error) return;
      end
      checks++;
      errors++;
      $display("FAIL %s: load never ended, done=0 error=0", name);
   endtask

   task automatic check_status(input string name, input logic e_done, input logic e_err,
                               input logic [15:0] e_words, input logic e_hold);
      check({name, "_done"}, 64'(done), 64'(e_done));
      check({name, "_error"}, 64'(error), 64'(e_err));
      check({name, "_words"}, 64'(words_written), 64'(e_words));
      check({name, "_cpu_hold"}, 64'(cpu_hold), 64'(e_hold));
      check({name, "_select"}, 64'(imem_select), 64'd0);
      check({name, "_busy"}, 64'(busy), 64'd0);
      check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_tready"}, 64'(bus.s_axis_tready), 64'd0);
      check({name, "_write"}, 64'(bus.avm_write), 64'd0);
      check({name, "_addr"}, 64'(bus.avm_address), 64'd0);
      check({name, "_wdata"}, 64'(bus.avm_writedata), 64'd0);
      check({name, "_select"}, 64'(imem_select), 64'd0);
      check({name, "_hold"}, 64'(cpu_hold), 64'd0);
      check({name, "_busy"}, 64'(busy), 64'd0);
      check({name, "_done"}, 64'(done), 64'd0);
      check({name, "_error"}, 64'(error), 64'd0);
      check({name, "_words"}, 64'(words_written), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw_ready;
      bit got_err;
      reset = 1'b1;
      start = 1'b0;
      base_addr = '0;
      bus.s_axis_tdata  = '0;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("reset");

      // 1: four words, no stalls
      tick();
      push(32'h0, 32'h11); push(32'h4, 32'h22); push(32'h8, 32'h33); push(32'hC, 32'h44);
      do_start(32'h0);
      send(32'h11, 1'b0); send(32'h22, 1'b0); send(32'h33, 1'b0); send(32'h44, 1'b1);
      wait_end("t1");
      check_status("t1", 1'b1, 1'b0, 16'd4, 1'b0);

      // 2: same load, 3 stall cycles per write
      tick();
      stall_n = 3;
      push(32'h0, 32'h11); push(32'h4, 32'h22); push(32'h8, 32'h33); push(32'hC, 32'h44);
      do_start(32'h0);
      send(32'h11, 1'b0); send(32'h22, 1'b0); send(32'h33, 1'b0); send(32'h44, 1'b1);
      wait_end("t2");
      check_status("t2", 1'b1, 1'b0, 16'd4, 1'b0);
      stall_n = 0;

      // 3: overflow at the top of imem, third word must be refused
      tick();
      push(32'h1FFF8, 32'hA1); push(32'h1FFFC, 32'hA2);
      do_start(32'h1FFF8);
      send(32'hA1, 1'b0); send(32'hA2, 1'b0);
      bus.s_axis_tdata  = 32'hA3;
      bus.s_axis_tvalid = 1'b1;
      saw_ready = 1'b0;
      got_err = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.s_axis_tready) saw_ready = 1'b1;
         if (error) got_err = 1'b1;
      end
      bus.s_axis_tvalid = 1'b0;
      check("t3_third_word_refused", 64'(saw_ready), 64'd0);
      check("t3_error_raised", 64'(got_err), 64'd1);
      check_status("t3", 1'b0, 1'b1, 16'd2, 1'b1);

      // 4: final in-range word with tlast completes normally
      tick();
      push(32'h1FFFC, 32'hB5);
      do_start(32'h1FFFC);
      send(32'hB5, 1'b1);
      wait_end("t4");
      check_status("t4", 1'b1, 1'b0, 16'd1, 1'b0);

      // 5: timeout of 8 idle cycles after the second write
      tick();
      push(32'h40, 32'hC1); push(32'h44, 32'hC2);
      do_start(32'h40);
      send(32'hC1, 1'b0); send(32'hC2, 1'b0);
      got_err = 1'b0;
      for (int n = 0; n < 40 && !got_err; n++) begin
         @(negedge clk);
         if (error) got_err = 1'b1;
      end
      check("t5_error_raised", 64'(got_err), 64'd1);
      check("t5_timeout_cycles", 64'(cyc - acc_edge), 64'd8);
      check_status("t5", 1'b0, 1'b1, 16'd2, 1'b1);

      // 6: start while busy, then reset in a stalled write
      tick();
      stall_n = 3;
      push(32'h0, 32'hD1);
      do_start(32'h2);
      send(32'hD1, 1'b0);
      send(32'hD2, 1'b0);
      base_addr = 32'h80;
      start = 1'b1;
      tick();
      @(negedge clk);
      check("t6_addr_after_start", 64'(bus.avm_address), 64'h4);
      check("t6_busy_after_start", 64'(busy), 64'd1);
      check("t6_words_after_start", 64'(words_written), 64'd1);
      check("t6_stalled_write", 64'(bus.avm_write & bus.avm_waitrequest), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_all_zero("t6_reset");
      @(negedge clk);
      check("t6_start_with_reset_busy", 64'(busy), 64'd0);
      check("t6_start_with_reset_tready", 64'(bus.s_axis_tready), 64'd0);
      check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
      stall_n = 0;

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
